counter_cmd_sched: RTL and testbench
====================================

// Module: counter_cmd_sched
// PURPOSE
//  Round-robin command scheduler that shares one up/down counter (load_n/ce/up_down/data_load/count_out)
//  between N_REQ requesters. Each requester issues NOP, LOAD value, or COUNT UP/DOWN by S steps.
//  Sequences the counter control pins and returns a response carrying final count and wrap flag.
//  Sits between requester logic and the counter, which shares clk and rst_n with this block.
// PARAMETERS
//  WIDTH   4  counter width (matches counter data_load/count_out)
//  N_REQ   2  number of requesters, >=2
//  STEP_W  8  argument width; must be >= WIDTH
// PORTS
//  clk        in   1             clock, all logic on posedge
//  rst_n      in   1             asynchronous active-low reset
//  req_valid  in   N_REQ         per-requester command valid
//  req_ready  out  N_REQ         one-hot accept; combinational = (state==IDLE) & grant
//  req_op     in   2*N_REQ       op per requester, slice [2i+1:2i]
//  req_arg    in   STEP_W*N_REQ  LOAD value (low WIDTH bits) or step count S
//  load_n     out  1             to counter, active-low synchronous load
//  ce         out  1             to counter, count enable
//  up_down    out  1             to counter, 1=up 0=down
//  data_load  out  WIDTH         to counter, load value
//  count_out  in   WIDTH         from counter, current count
//  rsp_valid  out  1             one-cycle response pulse, no backpressure
//  rsp_id     out  $clog2(N_REQ) index of requester being answered
//  rsp_count  out  WIDTH         count_out passthrough while rsp_valid
//  rsp_wrap   out  1             counter wrapped during this command
//  busy       out  1             state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, load_n=1, ce=0, up_down=1, data_load=0, rsp_valid=0, rsp_id=0, rsp_wrap=0,
//   RR pointer=0, step counter=0. Reset mid-command abandons it; no response is issued.
//  Ops: 00 NOP, 01 LOAD, 10 UP, 11 DOWN. load_n/ce/up_down/data_load are registered outputs.
//  IDLE: grant = first req_valid at or after pointer (wrapping). Handshake completes at edge where
//   req_valid[g]&req_ready[g]; latch op, arg, id=g, clear wrap, pointer<=(g+1)%N_REQ.
//   Next state: LOAD for LOAD; RUN for UP/DOWN with S!=0; RESP for NOP or S==0.
//  LOAD (1 cycle): load_n=0, data_load=arg[WIDTH-1:0]; counter loads at exit edge; -> RESP.
//  RUN (exactly S cycles): ce=1, up_down=(op==UP); remaining<=S at accept, decrement per cycle;
//   exit when remaining==1. Counter sees exactly S enabled edges; result = start +/- S mod 2^WIDTH.
//   wrap set (sticky) when ce & up & count_out=='1, or ce & !up & count_out==0.
//  RESP (1 cycle): rsp_valid=1, rsp_id, rsp_count=count_out, rsp_wrap; controls idle; -> IDLE.
//  Latency from accept edge to rsp_valid cycle: NOP 1, LOAD 2, UP/DOWN S+1.
//  Valid raised while busy waits; valid dropped before grant is never accepted. No grant in RESP,
//   so back-to-back commands have one idle cycle (IDLE) between RESP and next LOAD/RUN.
//  Outside LOAD/RUN: load_n=1, ce=0; up_down and data_load hold last value.
// STRUCTURE
//  Package counter_ctrl_pkg: typedef enum logic[1:0] op_e {OP_NOP,OP_LOAD,OP_UP,OP_DOWN};
//   typedef enum state_e {S_IDLE,S_LOAD,S_RUN,S_RESP}.
//  Sub-module counter_rr_arb #(N_REQ): combinational one-hot grant from req_valid and pointer,
//   plus pointer register updated on accept strobe.
//  Top: FSM, step down-counter, op/arg/id latches, wrap flag, output registers.
// TESTING
//  Reset -> all outputs at reset values; assert rst_n, no valid -> busy=0, ce=0, load_n=1.
//  Req0 LOAD 4'hA -> load_n low 1 cycle with data_load=A; rsp_valid 2 cycles after accept,
//   rsp_id=0, rsp_count=A, rsp_wrap=0.
//  After LOAD 4'hE, req1 UP S=3 -> ce high exactly 3 cycles; rsp_count=1, rsp_wrap=1, rsp_id=1.
//  LOAD 0 then DOWN S=1 -> rsp_count=F, rsp_wrap=1; UP S=0 -> no ce, rsp 1 cycle later, count unchanged.
//  Req0 and req1 valid continuously -> grants alternate 0,1,0,1; neither starves.
//  Reset asserted during RUN S=10 -> outputs to reset values immediately; no rsp_valid;
//   after release, next command is accepted normally with pointer=0.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter command scheduler: requester opcodes and FSM states.
package counter_ctrl_pkg;

    // Requester opcode carried on each req_op slice.
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_UP   = 2'b10,
        OP_DOWN = 2'b11
    } op_e;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RESP
    } state_e;

    // True for the ops that step the counter.
    function automatic logic is_count_op(input op_e op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage

// File: rtl/counter_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant to the first valid requester at or
// after the pointer (wrapping); pointer moves past the winner on each accept.
module counter_rr_arb #(
    parameter int unsigned N_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic                       accept_i,
    output logic [N_REQ-1:0]           grant_o,
    output logic [$clog2(N_REQ)-1:0]   grant_idx_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] idx;
    logic             found;

    // Scan requesters starting at the pointer; first valid one wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = IDX_W'((32'(ptr_q) + i) % N_REQ);
            if (!found && req_valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
                found        = 1'b1;
            end
        end
    end

    // Pointer value after the current winner, wrapping at N_REQ.
    always_comb begin
        ptr_d = (grant_idx_o == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_o + IDX_W'(1);
    end

    // Pointer register, advanced only when a handshake completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (accept_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/counter_cmd_sched.sv
// Round-robin command scheduler that drives a shared up/down counter on behalf of N_REQ
// requesters and returns the resulting count and a wrap flag for each command.
module counter_cmd_sched
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned STEP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [2*N_REQ-1:0]         req_op,
    input  logic [STEP_W*N_REQ-1:0]    req_arg,
    output logic                       load_n,
    output logic                       ce,
    output logic                       up_down,
    output logic [WIDTH-1:0]           data_load,
    input  logic [WIDTH-1:0]           count_out,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]           rsp_count,
    output logic                       rsp_wrap,
    output logic                       busy
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [STEP_W-1:0]   remaining_q, remaining_d;
    logic                wrap_q, wrap_d;
    logic                load_n_q, load_n_d;
    logic                ce_q, ce_d;
    logic                up_down_q, up_down_d;
    logic [WIDTH-1:0]    data_load_q, data_load_d;

    logic [N_REQ-1:0]    grant;
    logic [ID_W-1:0]     grant_idx;
    logic                accept;
    op_e                 op_sel;
    logic [STEP_W-1:0]   arg_sel;

    counter_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .accept_i    (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Select the granted requester's op and argument.
    always_comb begin
        op_sel  = OP_NOP;
        arg_sel = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant[i]) begin
                op_sel  = op_e'(req_op[2*i +: 2]);
                arg_sel = req_arg[STEP_W*i +: STEP_W];
            end
        end
    end

    // FSM next state, command latches and next values of the registered counter controls.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        remaining_d = remaining_q;
        wrap_d      = wrap_q;
        load_n_d    = 1'b1;
        ce_d        = 1'b0;
        up_down_d   = up_down_q;
        data_load_d = data_load_q;
        accept      = 1'b0;

        // The counter steps on this edge and is at its limit: record the wrap.
        if (ce_q && ((up_down_q && (count_out == {WIDTH{1'b1}})) ||
                     (!up_down_q && (count_out == '0)))) begin
            wrap_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    accept = 1'b1;
                    op_d   = op_sel;
                    id_d   = grant_idx;
                    wrap_d = 1'b0;
                    if (op_sel == OP_LOAD) begin
                        state_d     = S_LOAD;
                        load_n_d    = 1'b0;
                        data_load_d = arg_sel[WIDTH-1:0];
                    end else if (is_count_op(op_sel) && (arg_sel != '0)) begin
                        state_d     = S_RUN;
                        ce_d        = 1'b1;
                        up_down_d   = (op_sel == OP_UP);
                        remaining_d = arg_sel;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_RESP;
            end
            S_RUN: begin
                remaining_d = remaining_q - STEP_W'(1);
                if (remaining_q == STEP_W'(1)) begin
                    state_d = S_RESP;
                end else begin
                    ce_d      = 1'b1;
                    up_down_d = (op_q == OP_UP);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latches and counter-control output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NOP;
            id_q        <= '0;
            remaining_q <= '0;
            wrap_q      <= 1'b0;
            load_n_q    <= 1'b1;
            ce_q        <= 1'b0;
            up_down_q   <= 1'b1;
            data_load_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            id_q        <= id_d;
            remaining_q <= remaining_d;
            wrap_q      <= wrap_d;
            load_n_q    <= load_n_d;
            ce_q        <= ce_d;
            up_down_q   <= up_down_d;
            data_load_q <= data_load_d;
        end
    end

    // Outputs: counter controls come straight from registers; response decodes RESP.
    always_comb begin
        load_n    = load_n_q;
        ce        = ce_q;
        up_down   = up_down_q;
        data_load = data_load_q;
        busy      = (state_q != S_IDLE);
        req_ready = grant & {N_REQ{state_q == S_IDLE}};
        rsp_valid = (state_q == S_RESP);
        rsp_id    = id_q;
        rsp_count = rsp_valid ? count_out : '0;
        rsp_wrap  = rsp_valid & wrap_q;
    end

endmodule

// File: tb/tb_counter_cmd_sched.sv
// Self-checking bench for counter_cmd_sched with a behavioural counter attached to its pins
// and an arithmetic reference model of command results.
module tb_counter_cmd_sched;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_arg;
    logic        load_n, ce, up_down;
    logic [3:0]  data_load, count_out, rsp_count;
    logic        rsp_valid, rsp_wrap, busy;
    logic [0:0]  rsp_id;
    logic [3:0]  cnt_q;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    int model_ptr = 0;

    counter_cmd_sched #(
        .WIDTH  (4),
        .N_REQ  (2),
        .STEP_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_arg   (req_arg),
        .load_n    (load_n),
        .ce        (ce),
        .up_down   (up_down),
        .data_load (data_load),
        .count_out (count_out),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_count (rsp_count),
        .rsp_wrap  (rsp_wrap),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External counter sharing clk/rst_n with the scheduler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt_q <= 4'h0;
        else if (!load_n) cnt_q <= data_load;
        else if (ce)      cnt_q <= up_down ? cnt_q + 4'h1 : cnt_q - 4'h1;
    end
    assign count_out = cnt_q;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    // Expected result of one command from the starting count.
    function automatic void ref_cmd(input logic [1:0] op, input int arg, input int start,
                                    output int res, output int wr, output int lat,
                                    output int nce, output int nld);
        res = start; wr = 0; lat = 1; nce = 0; nld = 0;
        case (op)
            OP_LOAD: begin res = arg % 16; lat = 2; nld = 1; end
            OP_UP:   begin res = (start + arg) % 16; wr = (start + arg > 15); lat = arg + 1;
                           nce = arg; end
            OP_DOWN: begin res = (start - arg) & 15; wr = (arg > start); lat = arg + 1;
                           nce = arg; end
            default: ;
        endcase
    endfunction

    // Issue one command from requester id and observe it through to its response.
    task automatic do_cmd(input int id, input logic [1:0] op, input logic [7:0] arg,
                          output int lat, output int rid, output logic [3:0] rcnt,
                          output logic rwr, output int nce, output int nld,
                          output logic [3:0] ldv);
        int waited;
        lat = -1; rid = -1; rcnt = 4'h0; rwr = 1'b0; nce = 0; nld = 0; ldv = 4'h0;
        @(negedge clk);
        req_op[2*id +: 2]  = op;
        req_arg[8*id +: 8] = arg;
        req_valid[id]      = 1'b1;
        #1;
        waited = 0;
        while (!req_ready[id] && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!req_ready[id]) begin
            checks++; errors++;
            $display("FAIL accept_timeout id=%0d: req_ready=0, required 1", id);
            req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk); #1;
            if (ce) nce++;
            if (!load_n) begin nld++; ldv = data_load; end
            if (rsp_valid) begin
                lat = n; rid = int'(rsp_id); rcnt = rsp_count; rwr = rsp_wrap;
                break;
            end
        end
        model_ptr = (id + 1) % 2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b00; req_op = '0; req_arg = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (load_n !== 1'b1) begin errors++; $display("FAIL rst_load_n: got %b, expected 1", load_n); end
        checks++; if (ce !== 1'b0) begin errors++; $display("FAIL rst_ce: got %b, expected 0", ce); end
        checks++; if (up_down !== 1'b1) begin errors++; $display("FAIL rst_up_down: got %b, expected 1", up_down); end
        checks++; if (data_load !== 4'h0) begin errors++; $display("FAIL rst_data_load: got %h, expected 0", data_load); end
        checks++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_wrap !== 1'b0) begin errors++;
            $display("FAIL rst_rsp: got v=%b id=%b w=%b, expected 0 0 0", rsp_valid, rsp_id, rsp_wrap); end
        checks++; if (busy !== 1'b0 || req_ready !== 2'b00) begin errors++;
            $display("FAIL rst_busy_ready: got %b %b, expected 0 00", busy, req_ready); end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0 || ce !== 1'b0 || load_n !== 1'b1) begin errors++;
            $display("FAIL idle_after_rst: got busy=%b ce=%b load_n=%b, expected 0 0 1", busy, ce, load_n); end
        model_cnt = 0; model_ptr = 0;
    endtask

    task automatic test_load();
        int lat, rid, nce, nld; logic [3:0] rc, ldv; logic rw;
        do_cmd(0, OP_LOAD, 8'h5A, lat, rid, rc, rw, nce, nld, ldv);
        checks++; if (nld !== 1 || ldv !== 4'hA) begin errors++;
            $display("FAIL load_pins: got %0d cycles value %h, expected 1 cycle value a", nld, ldv); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency: got %0d, expected 2", lat); end
        checks++; if (rid !== 0 || rc !== 4'hA || rw !== 1'b0) begin errors++;
            $display("FAIL load_rsp: got id=%0d cnt=%h wrap=%b, expected 0 a 0", rid, rc, rw); end
        checks++; if (nce !== 0) begin errors++; $display("FAIL load_no_ce: got %0d, expected 0", nce); end
        model_cnt = 10;
    endtask

    task automatic test_up_wrap();
        int lat, rid, nce, nld; logic [3:0] rc, ldv; logic rw;
        do_cmd(0, OP_LOAD, 8'h0E, lat, rid, rc, rw, nce, nld, ldv);
        checks++; if (rc !== 4'hE) begin errors++; $display("FAIL upw_load: got %h, expected e", rc); end
        do_cmd(1, OP_UP, 8'd3, lat, rid, rc, rw, nce, nld, ldv);
        checks++; if (nce !== 3) begin errors++; $display("FAIL upw_ce_cycles: got %0d, expected 3", nce); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL upw_latency: got %0d, expected 4", lat); end
        checks++; if (rid !== 1 || rc !== 4'h1 || rw !== 1'b1) begin errors++;
            $display("FAIL upw_rsp: got id=%0d cnt=%h wrap=%b, expected 1 1 1", rid, rc, rw); end
        model_cnt = 1;
    endtask

    task automatic test_down_zero();
        int lat, rid, nce, nld; logic [3:0] rc, ldv; logic rw;
        do_cmd(0, OP_LOAD, 8'h00, lat, rid, rc, rw, nce, nld, ldv);
        do_cmd(1, OP_DOWN, 8'd1, lat, rid, rc, rw, nce, nld, ldv);
        checks++; if (rc !== 4'hF || rw !== 1'b1 || lat !== 2 || nce !== 1) begin errors++;
            $display("FAIL down1: got cnt=%h wrap=%b lat=%0d ce=%0d, expected f 1 2 1", rc, rw, lat, nce); end
        do_cmd(0, OP_UP, 8'd0, lat, rid, rc, rw, nce, nld, ldv);
        checks++; if (rc !== 4'hF || rw !== 1'b0 || lat !== 1 || nce !== 0) begin errors++;
            $display("FAIL up0: got cnt=%h wrap=%b lat=%0d ce=%0d, expected f 0 1 0", rc, rw, lat, nce); end
        do_cmd(1, OP_NOP, 8'h77, lat, rid, rc, rw, nce, nld, ldv);
        checks++; if (rc !== 4'hF || rw !== 1'b0 || lat !== 1 || rid !== 1 || nld !== 0) begin errors++;
            $display("FAIL nop: got cnt=%h wrap=%b lat=%0d id=%0d ld=%0d, expected f 0 1 1 0",
                     rc, rw, lat, rid, nld); end
        model_cnt = 15;
    endtask

    // Both requesters hold valid with NOPs: grants alternate, responses every other cycle.
    task automatic test_back_to_back();
        int g_seen, r_seen, last_rsp, first;
        logic [1:0] exp_ready;
        g_seen = 0; r_seen = 0; last_rsp = -10; first = model_ptr;
        @(negedge clk);
        req_op = {OP_NOP, OP_NOP}; req_arg = '0; req_valid = 2'b11;
        #1;
        for (int c = 0; c < 60 && r_seen < 6; c++) begin
            if (busy && req_ready !== 2'b00) begin
                checks++; errors++;
                $display("FAIL b2b_ready_busy: got %b, expected 00", req_ready);
            end
            if (rsp_valid) begin
                checks++;
                if (int'(rsp_id) !== (first + r_seen) % 2 || rsp_count !== 4'(model_cnt) ||
                    (r_seen > 0 && c - last_rsp != 2)) begin
                    errors++;
                    $display("FAIL b2b_rsp%0d: got id=%0d cnt=%h gap=%0d, expected %0d %h 2",
                             r_seen, rsp_id, rsp_count, c - last_rsp, (first + r_seen) % 2,
                             model_cnt);
                end
                last_rsp = c; r_seen++;
            end
            if (!busy && req_valid != 2'b00) begin
                exp_ready = 2'b01 << ((first + g_seen) % 2);
                checks++;
                if (req_ready !== exp_ready) begin
                    errors++;
                    $display("FAIL b2b_grant%0d: got %b, expected %b", g_seen, req_ready, exp_ready);
                end
                g_seen++;
            end
            if (g_seen == 6 && req_valid != 2'b00) begin
                @(posedge clk); #1;
                req_valid = 2'b00;
            end
            @(negedge clk); #1;
        end
        checks++; if (r_seen !== 6) begin errors++;
            $display("FAIL b2b_count: got %0d responses, expected 6", r_seen); end
    endtask

    task automatic test_reset_mid_run();
        int lat, rid, nce, nld, waited, extra; logic [3:0] rc, ldv; logic rw;
        do_cmd(1, OP_LOAD, 8'h05, lat, rid, rc, rw, nce, nld, ldv);
        @(negedge clk);
        req_op[1:0] = OP_UP; req_arg[7:0] = 8'd10; req_valid[0] = 1'b1;
        #1;
        waited = 0;
        while (!req_ready[0] && waited < 20) begin @(negedge clk); #1; waited++; end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (ce !== 1'b1) begin errors++; $display("FAIL mid_run_ce: got %b, expected 1", ce); end
        rst_n = 1'b0;
        #1;
        checks++; if (ce !== 1'b0 || load_n !== 1'b1 || up_down !== 1'b1 || data_load !== 4'h0) begin
            errors++;
            $display("FAIL async_rst_ctrl: got ce=%b load_n=%b up=%b dl=%h, expected 0 1 1 0",
                     ce, load_n, up_down, data_load);
        end
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_wrap !== 1'b0) begin errors++;
            $display("FAIL async_rst_rsp: got busy=%b v=%b w=%b, expected 0 0 0", busy, rsp_valid, rsp_wrap); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (rsp_valid || busy) extra++;
        end
        checks++; if (extra !== 0) begin errors++;
            $display("FAIL abandoned_cmd: got %0d active cycles, expected 0", extra); end
        model_cnt = 0;
        @(negedge clk);
        req_op = {OP_LOAD, OP_LOAD}; req_arg = {8'h09, 8'h07}; req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++;
            $display("FAIL ptr_after_rst: got ready=%b, expected 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        lat = -1; extra = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk); #1;
            if (rsp_valid) begin
                if (lat < 0) begin lat = n; rid = int'(rsp_id); rc = rsp_count; end
                else extra++;
            end
        end
        checks++; if (lat !== 2 || rid !== 0 || rc !== 4'h7 || extra !== 0) begin errors++;
            $display("FAIL post_rst_cmd: got lat=%0d id=%0d cnt=%h extra=%0d, expected 2 0 7 0",
                     lat, rid, rc, extra); end
        model_cnt = 7; model_ptr = 1;
    endtask

    task automatic test_random();
        int lat, rid, nce, nld, id, arg, e_res, e_wr, e_lat, e_nce, e_nld;
        logic [3:0] rc, ldv; logic rw; logic [1:0] op; logic [7:0] arg8;
        for (int k = 0; k < 40; k++) begin
            id  = int'($urandom_range(0, 1));
            op  = 2'($urandom_range(0, 3));
            arg = (op == OP_LOAD) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
            arg8 = 8'(arg);
            ref_cmd(op, arg, model_cnt, e_res, e_wr, e_lat, e_nce, e_nld);
            do_cmd(id, op, arg8, lat, rid, rc, rw, nce, nld, ldv);
            checks++;
            if (lat !== e_lat || rid !== id) begin
                errors++;
                $display("FAIL rnd%0d_lat_id: got lat=%0d id=%0d, expected %0d %0d", k, lat, rid, e_lat, id);
            end
            checks++;
            if (int'(rc) !== e_res || int'(rw) !== e_wr) begin
                errors++;
                $display("FAIL rnd%0d_result op=%0d arg=%0d: got cnt=%h wrap=%b, expected %h %0d",
                         k, op, arg, rc, rw, e_res, e_wr);
            end
            checks++;
            if (nce !== e_nce || nld !== e_nld || (e_nld == 1 && int'(ldv) !== arg % 16)) begin
                errors++;
                $display("FAIL rnd%0d_pins: got ce=%0d ld=%0d val=%h, expected %0d %0d %h",
                         k, nce, nld, ldv, e_nce, e_nld, arg % 16);
            end
            model_cnt = e_res;
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_up_wrap();
        test_down_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
